// File: rtl/icache_refill_ctrl_if.sv
// Signal bundle between the fetch-stage cache, the instruction memory port
// and the refill sequencer. master = sequencer side, slave = environment side.
interface icache_refill_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    // fetch stage
    logic              fetch_valid;
    logic [ADDR_W-1:0] fetch_addr;
    logic              cache_hit;
    logic              stall;
    // instruction memory port
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    // cache fill port
    logic              fill_we;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;
    logic              fill_done;
    logic [CNT_W-1:0]  miss_count;

    modport master (
        input  fetch_valid, fetch_addr, cache_hit, mem_rvalid, mem_rdata,
        output stall, mem_req, mem_addr, fill_we, fill_addr, fill_data,
               fill_done, miss_count
    );

    modport slave (
        output fetch_valid, fetch_addr, cache_hit, mem_rvalid, mem_rdata,
        input  stall, mem_req, mem_addr, fill_we, fill_addr, fill_data,
               fill_done, miss_count
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss sequencer: stalls fetch, refills one line word by word
// (critical word first, one outstanding read), then validates the line.
module icache_refill_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    icache_refill_ctrl_if.master bus
);
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W = IDX_W + 2;
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((1 << OFF_W) - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_line_base;
    logic [IDX_W-1:0]    r_start_idx;
    logic [IDX_W-1:0]    r_word_cnt;
    logic [CNT_W-1:0]    r_miss_count;

    logic                w_miss;
    logic                w_last_word;
    logic [IDX_W-1:0]    w_word_idx;
    logic [ADDR_W-1:0]   w_word_addr;

    logic                w_stall;
    logic                w_mem_req;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic                w_fill_we;
    logic [ADDR_W-1:0]   w_fill_addr;
    logic [DATA_W-1:0]   w_fill_data;
    logic                w_fill_done;

    assign w_miss      = bus.fetch_valid & ~bus.cache_hit;
    // IDX_W-bit sum wraps inside the line, so the offset never carries into line_base
    assign w_word_idx  = r_start_idx + r_word_cnt;
    assign w_word_addr = r_line_base + (ADDR_W'(w_word_idx) << 2);
    assign w_last_word = (r_word_cnt == IDX_W'(LINE_WORDS - 1));

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state      <= ST_IDLE;
            r_line_base  <= '0;
            r_start_idx  <= '0;
            r_word_cnt   <= '0;
            r_miss_count <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_miss) begin
                        r_line_base <= bus.fetch_addr & ~LINE_MASK;
                        r_start_idx <= bus.fetch_addr[OFF_W-1:2];
                        r_word_cnt  <= '0;
                        if (r_miss_count != '1) begin
                            r_miss_count <= r_miss_count + 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.mem_rvalid && !w_last_word) begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_mem_req    = 1'b0;
        w_mem_addr   = '0;
        w_fill_we    = 1'b0;
        w_fill_addr  = '0;
        w_fill_data  = '0;
        w_fill_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stall = w_miss;
                if (w_miss) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                w_stall      = 1'b1;
                w_mem_req    = 1'b1;
                w_mem_addr   = w_word_addr;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                w_stall = 1'b1;
                if (bus.mem_rvalid) begin
                    w_fill_we    = 1'b1;
                    w_fill_addr  = w_word_addr;
                    w_fill_data  = bus.mem_rdata;
                    w_state_next = w_last_word ? ST_DONE : ST_REQ;
                end
            end
            ST_DONE: begin
                w_stall      = 1'b1;
                w_fill_done  = 1'b1;
                w_fill_addr  = r_line_base;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.stall      = w_stall;
    assign bus.mem_req    = w_mem_req;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.fill_we    = w_fill_we;
    assign bus.fill_addr  = w_fill_addr;
    assign bus.fill_data  = w_fill_data;
    assign bus.fill_done  = w_fill_done;
    assign bus.miss_count = r_miss_count;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: a 16-bit-counter instance and a 2-bit-counter
// instance share stimulus; refills are checked against an arithmetic line model.
module tb_icache_refill_ctrl;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    icache_refill_ctrl_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) bus ();
    icache_refill_ctrl_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(2))  bus_sat ();

    assign bus_sat.fetch_valid = bus.fetch_valid;
    assign bus_sat.fetch_addr  = bus.fetch_addr;
    assign bus_sat.cache_hit   = bus.cache_hit;
    assign bus_sat.mem_rvalid  = bus.mem_rvalid;
    assign bus_sat.mem_rdata   = bus.mem_rdata;

    icache_refill_ctrl #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(LW), .CNT_W(16)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.master)
    );

    icache_refill_ctrl #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(LW), .CNT_W(2)) u_dut_sat (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_sat.master)
    );

    int errors = 0;
    int checks = 0;
    int n_misses = 0;
    int cur_lat[LW];
    logic [31:0] cur_data[LW];

    function automatic logic [15:0] exp_cnt_wide();
        return (n_misses > 65535) ? 16'hFFFF : 16'(n_misses);
    endfunction

    function automatic logic [1:0] exp_cnt_sat();
        return (n_misses > 3) ? 2'd3 : 2'(n_misses);
    endfunction

    task automatic drive_idle();
        bus.fetch_valid = 1'b0;
        bus.fetch_addr  = $urandom;
        bus.cache_hit   = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = $urandom;
    endtask

    // Drives one complete miss and checks every cycle of the refill.
    task automatic run_miss(input logic [31:0] addr, input string name);
        logic [31:0] base;
        logic [31:0] exp_addr[LW];
        logic [31:0] req_addr[$];
        int sidx, nfill, stall_cyc, exp_stall, due, cyc, nreq;
        bit pending, done, rv;
        base = addr & ~32'hF;
        sidx = int'((addr >> 2) % LW);
        exp_stall = 2;
        for (int k = 0; k < LW; k++) begin
            exp_addr[k] = base + 32'(4 * ((sidx + k) % LW));
            exp_stall += 1 + cur_lat[k];
        end
        n_misses++;
        pending = 0; done = 0; nfill = 0; stall_cyc = 0; cyc = 0; due = 0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            if (cyc == 0) begin
                bus.fetch_valid = 1'b1;
                bus.fetch_addr  = addr;
                bus.cache_hit   = 1'b0;
            end else begin
                bus.fetch_valid = 1'($urandom);
                bus.fetch_addr  = $urandom;
                bus.cache_hit   = 1'($urandom);
            end
            rv = pending && (cyc == due);
            bus.mem_rvalid = rv;
            bus.mem_rdata  = rv ? cur_data[nfill % LW] : $urandom;
            #1;
            if (bus.stall === 1'b1) stall_cyc++;
            checks++;
            if (bus.fill_we !== rv) begin
                errors++;
                $display("FAIL %s fill_we cyc=%0d got=%b exp=%b", name, cyc, bus.fill_we, rv);
            end
            if (rv) begin
                checks += 2;
                if (bus.fill_addr !== exp_addr[nfill % LW]) begin
                    errors++;
                    $display("FAIL %s fill_addr word=%0d got=%h exp=%h", name, nfill, bus.fill_addr, exp_addr[nfill % LW]);
                end
                if (bus.fill_data !== cur_data[nfill % LW]) begin
                    errors++;
                    $display("FAIL %s fill_data word=%0d got=%h exp=%h", name, nfill, bus.fill_data, cur_data[nfill % LW]);
                end
                nfill++;
                pending = 0;
            end
            checks++;
            if (((bus.mem_req & bus.fill_we) | (bus.fill_we & bus.fill_done)) !== 1'b0) begin
                errors++;
                $display("FAIL %s exclusive cyc=%0d req=%b we=%b done=%b exp=none_together", name, cyc, bus.mem_req, bus.fill_we, bus.fill_done);
            end
            if (bus.mem_req === 1'b1) begin
                checks++;
                if (pending !== 1'b0) begin
                    errors++;
                    $display("FAIL %s overlap cyc=%0d got=second_req exp=no_req", name, cyc);
                end
                req_addr.push_back(bus.mem_addr);
                nreq = req_addr.size();
                pending = 1;
                due = cyc + cur_lat[(nreq - 1) % LW];
            end
            if (bus.fill_done === 1'b1) begin
                done = 1;
                checks++;
                if (bus.fill_addr !== base) begin
                    errors++;
                    $display("FAIL %s fill_done_addr got=%h exp=%h", name, bus.fill_addr, base);
                end
            end
            cyc++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout got=no_fill_done exp=fill_done", name);
        end
        checks++;
        if (req_addr.size() != LW) begin
            errors++;
            $display("FAIL %s req_count got=%0d exp=%0d", name, req_addr.size(), LW);
        end
        for (int k = 0; k < LW && k < req_addr.size(); k++) begin
            checks++;
            if (req_addr[k] !== exp_addr[k]) begin
                errors++;
                $display("FAIL %s mem_addr[%0d] got=%h exp=%h", name, k, req_addr[k], exp_addr[k]);
            end
        end
        checks += 4;
        if (nfill != LW) begin
            errors++;
            $display("FAIL %s fill_count got=%0d exp=%0d", name, nfill, LW);
        end
        if (stall_cyc != exp_stall) begin
            errors++;
            $display("FAIL %s stall_cycles got=%0d exp=%0d", name, stall_cyc, exp_stall);
        end
        if (bus.miss_count !== exp_cnt_wide()) begin
            errors++;
            $display("FAIL %s miss_count got=%0d exp=%0d", name, bus.miss_count, exp_cnt_wide());
        end
        if (bus_sat.miss_count !== exp_cnt_sat()) begin
            errors++;
            $display("FAIL %s miss_count_sat got=%0d exp=%0d", name, bus_sat.miss_count, exp_cnt_sat());
        end
        // replayed fetch now hits
        @(negedge clk);
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = addr;
        bus.cache_hit   = 1'b1;
        bus.mem_rvalid  = 1'b0;
        #1;
        checks++;
        if ({bus.stall, bus.mem_req} !== 2'b00) begin
            errors++;
            $display("FAIL %s replay stall/req got=%b exp=00", name, {bus.stall, bus.mem_req});
        end
        $display("%s: addr=%h base=%h stall_cycles=%0d reqs=%0d fills=%0d miss_count=%0d",
                 name, addr, base, stall_cyc, req_addr.size(), nfill, bus.miss_count);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rstn = 1'b1;
        drive_idle();
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        drive_idle();
        #1;
        checks += 3;
        if ({bus.stall, bus.mem_req, bus.fill_we, bus.fill_done} !== 4'b0) begin
            errors++;
            $display("FAIL reset ctrl got=%b exp=0000", {bus.stall, bus.mem_req, bus.fill_we, bus.fill_done});
        end
        if ({bus.mem_addr, bus.fill_addr, bus.fill_data} !== 96'b0) begin
            errors++;
            $display("FAIL reset buses got=%h/%h/%h exp=0", bus.mem_addr, bus.fill_addr, bus.fill_data);
        end
        if ({bus.miss_count, bus_sat.miss_count} !== 18'b0) begin
            errors++;
            $display("FAIL reset miss_count got=%0d/%0d exp=0", bus.miss_count, bus_sat.miss_count);
        end
        n_misses = 0;
        $display("reset: stall=%b miss_count=%0d", bus.stall, bus.miss_count);
    endtask

    task automatic test_hit_path();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.fetch_valid = 1'b1;
            bus.fetch_addr  = $urandom;
            bus.cache_hit   = 1'b1;
            bus.mem_rvalid  = 1'($urandom);
            bus.mem_rdata   = $urandom;
            #1;
            checks += 2;
            if ({bus.stall, bus.mem_req, bus.fill_we, bus.fill_done} !== 4'b0) begin
                errors++;
                $display("FAIL hit_path ctrl cyc=%0d got=%b exp=0000", i, {bus.stall, bus.mem_req, bus.fill_we, bus.fill_done});
            end
            if (bus.miss_count !== exp_cnt_wide()) begin
                errors++;
                $display("FAIL hit_path miss_count got=%0d exp=%0d", bus.miss_count, exp_cnt_wide());
            end
            $display("hit: addr=%h stall=%b miss_count=%0d", bus.fetch_addr, bus.stall, bus.miss_count);
        end
    endtask

    task automatic test_aligned_miss();
        for (int k = 0; k < LW; k++) begin
            cur_lat[k]  = 1;
            cur_data[k] = 32'hA0 + 32'(k);
        end
        run_miss(32'h0000_0040, "aligned_miss");
    endtask

    task automatic test_wrap();
        for (int k = 0; k < LW; k++) begin
            cur_lat[k]  = 1;
            cur_data[k] = $urandom;
        end
        run_miss(32'h0000_0178, "wrap_miss");
    endtask

    task automatic test_var_latency();
        cur_lat[0] = 3; cur_lat[1] = 1; cur_lat[2] = 5; cur_lat[3] = 2;
        for (int k = 0; k < LW; k++) cur_data[k] = $urandom;
        run_miss($urandom, "var_latency");
    endtask

    task automatic test_random();
        for (int t = 0; t < 20; t++) begin
            for (int k = 0; k < LW; k++) begin
                cur_lat[k]  = int'($urandom_range(4, 1));
                cur_data[k] = $urandom;
            end
            run_miss($urandom, "random_miss");
            repeat ($urandom_range(3, 0)) begin
                @(negedge clk);
                bus.fetch_valid = 1'($urandom);
                bus.fetch_addr  = $urandom;
                bus.cache_hit   = 1'b1;
                bus.mem_rvalid  = 1'($urandom);
                #1;
                checks++;
                if ({bus.stall, bus.mem_req, bus.fill_we} !== 3'b000) begin
                    errors++;
                    $display("FAIL random_gap ctrl got=%b exp=000", {bus.stall, bus.mem_req, bus.fill_we});
                end
            end
        end
    endtask

    task automatic test_reset_mid_refill();
        int fills, cyc;
        bit prev_req;
        @(negedge clk);
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = $urandom;
        bus.cache_hit   = 1'b0;
        bus.mem_rvalid  = 1'b0;
        fills = 0; cyc = 0; prev_req = 0;
        while (fills < 2 && cyc < 50) begin
            @(negedge clk);
            bus.fetch_valid = 1'($urandom);
            bus.fetch_addr  = $urandom;
            bus.cache_hit   = 1'($urandom);
            bus.mem_rvalid  = prev_req;
            bus.mem_rdata   = $urandom;
            #1;
            if (bus.fill_we === 1'b1) fills++;
            prev_req = (bus.mem_req === 1'b1);
            cyc++;
        end
        checks++;
        if (fills != 2) begin
            errors++;
            $display("FAIL reset_mid fill_count got=%0d exp=2", fills);
        end
        @(negedge clk);
        rstn = 1'b1;
        drive_idle();
        @(negedge clk);
        rstn = 1'b0;
        drive_idle();
        #1;
        n_misses = 0;
        checks += 2;
        if ({bus.stall, bus.mem_req, bus.fill_we, bus.fill_done} !== 4'b0) begin
            errors++;
            $display("FAIL reset_mid ctrl got=%b exp=0000", {bus.stall, bus.mem_req, bus.fill_we, bus.fill_done});
        end
        if ({bus.miss_count, bus_sat.miss_count} !== 18'b0) begin
            errors++;
            $display("FAIL reset_mid miss_count got=%0d/%0d exp=0", bus.miss_count, bus_sat.miss_count);
        end
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = $urandom;
        #1;
        checks++;
        if ({bus.fill_we, bus.fill_done, bus.stall} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid stray_rvalid got=%b exp=000", {bus.fill_we, bus.fill_done, bus.stall});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            #1;
            checks++;
            if (bus.fill_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid late_fill_done got=%b exp=0", bus.fill_done);
            end
        end
        $display("reset_mid_refill: fills_before_reset=%0d miss_count=%0d", fills, bus.miss_count);
    endtask

    task automatic test_saturation();
        logic [1:0] exp_seq[5];
        exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd3;
        exp_seq[3] = 2'd3; exp_seq[4] = 2'd3;
        for (int m = 0; m < 5; m++) begin
            for (int k = 0; k < LW; k++) begin
                cur_lat[k]  = int'($urandom_range(2, 1));
                cur_data[k] = $urandom;
            end
            run_miss($urandom, "saturation_miss");
            checks++;
            if (bus_sat.miss_count !== exp_seq[m]) begin
                errors++;
                $display("FAIL saturation miss=%0d got=%0d exp=%0d", m + 1, bus_sat.miss_count, exp_seq[m]);
            end
        end
    endtask

    initial begin
        rstn = 1'b1;
        drive_idle();
        test_reset();
        test_hit_path();
        test_aligned_miss();
        test_wrap();
        test_var_latency();
        test_random();
        test_reset_mid_refill();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
Miss-handling sequencer for the instruction-fetch stage. It detects an instruction-cache miss, stalls the PC register and the IF/ID pipeline register, and refills one cache line from instruction memory one word at a time, critical word first. It writes each word into the cache and validates the line, then releases the stall. It sits between the fetch-stage cache and the instruction memory port.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, instruction word width
LINE_WORDS, 4, words per cache line (power of 2, >=2)
CNT_W, 16, width of the saturating miss counter

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  synchronous reset, active-high (asserted = 1), sampled on the clk edge
fetch_valid  in  1  fetch stage presents a valid fetch_addr this cycle
fetch_addr  in  ADDR_W  byte address of the current fetch (PC)
cache_hit  in  1  cache lookup hit for fetch_addr
stall  out  1  freeze the PC register and the IF/ID pipeline register
mem_req  out  1  single-word read request to instruction memory
mem_addr  out  ADDR_W  word-aligned byte address for mem_req
mem_rvalid  in  1  read data valid (arbitrary latency >=1 cycle after mem_req)
mem_rdata  in  DATA_W  read data
fill_we  out  1  write one word into the cache data array
fill_addr  out  ADDR_W  word-aligned byte address of the word being written
fill_data  out  DATA_W  word being written
fill_done  out  1  one-cycle pulse: set tag/valid for line base fill_addr
miss_count  out  CNT_W  saturating count of misses serviced

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset puts the FSM in IDLE with all outputs 0 and miss_count = 0.
- IDLE:
  - stall = fetch_valid & ~cache_hit (combinational).
  - On that condition, latch line_base = fetch_addr with its low log2(LINE_WORDS)+2 bits cleared.
  - Latch start_idx = the word index of fetch_addr, set word_cnt = 0, increment miss_count (saturating at all-ones), and go to REQ.
- REQ:
  - stall = 1, mem_req = 1 for exactly one cycle.
  - mem_addr = line_base + 4*((start_idx + word_cnt) mod LINE_WORDS). The index wraps, so the critical word is fetched first.
  - Next state is WAIT.
- WAIT:
  - stall = 1, mem_req = 0. Only one request is outstanding at a time.
  - On mem_rvalid: fill_we = 1 in the same cycle, fill_addr = the address just requested, fill_data = mem_rdata.
  - On the same mem_rvalid, if word_cnt == LINE_WORDS-1, go to DONE; otherwise increment word_cnt and go to REQ.
  - mem_rvalid seen in IDLE, REQ or DONE is ignored.
- DONE:
  - stall = 1, fill_done = 1 for one cycle, fill_addr = line_base. Next state is IDLE.
  - The replayed fetch hits in the following cycle, so the minimum miss penalty is 2*LINE_WORDS+2 cycles when memory latency is 1.
- fetch_addr and fetch_valid changes during REQ, WAIT and DONE are ignored. A PC redirect cannot occur because stall freezes the PC. The latched line_base and start_idx are used throughout the refill.
- Reset asserted mid-refill: return to IDLE on that edge and clear all outputs and miss_count. No fill_done is issued, so the partial line stays invalid. Any late mem_rvalid is ignored.
- fill_we and fill_done are never asserted in the same cycle. mem_req and fill_we are never asserted in the same cycle.
- Address arithmetic is modulo 2^ADDR_W. The word index wraps only within the line and never carries into line_base.

Test Plan:
1. Hit path: fetch_valid=1, cache_hit=1 for 10 cycles -> stall=0, mem_req=0, miss_count=0 throughout.
2. Aligned miss: fetch_addr=0x0000_0040, miss, memory latency 1, data 0xA0..0xA3.
   - mem_addr sequence 0x40, 0x44, 0x48, 0x4C.
   - fill_we four times with matching data.
   - fill_done with fill_addr=0x40.
   - stall high for exactly 10 cycles; miss_count=1.
3. Critical-word-first wrap: fetch_addr=0x0000_0178 -> mem_addr sequence 0x178, 0x17C, 0x170, 0x174; fill_done with fill_addr=0x170.
4. Variable latency: mem_rvalid delayed 3, 1, 5 and 2 cycles on successive words -> one mem_req per word, no new request while waiting, and fill_we only in the mem_rvalid cycles.
5. Reset mid-refill: assert rstn=1 after the second fill_we.
   - Next cycle: state IDLE, stall=0, miss_count=0, no fill_done.
   - A stray mem_rvalid one cycle later produces no fill_we.
6. Counter saturation: with CNT_W=2, service 5 misses -> miss_count reads 1, 2, 3, 3, 3.
